// File: rtl/pc_unit.sv
// Program-counter sequencer for the stack-processor fetch stage.
// Provides sequential, branch, jump, call and return modes, with a circular return-address stack.
module pc_unit #(
  parameter int WIDTH     = 16,
  parameter int INC       = 2,
  parameter int RESET_PC  = 0,
  parameter int RAS_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pc_write,
  input  logic [2:0]                       mode,
  input  logic                             branch_taken,
  input  logic [WIDTH-1:0]                 offset,
  input  logic [WIDTH-1:0]                 target,
  output logic [WIDTH-1:0]                 pc,
  output logic [WIDTH-1:0]                 pc_plus,
  output logic                             ras_empty,
  output logic                             ras_full,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_err
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  localparam logic [2:0] MODE_BRANCH = 3'b001;
  localparam logic [2:0] MODE_JUMP   = 3'b010;
  localparam logic [2:0] MODE_CALL   = 3'b011;
  localparam logic [2:0] MODE_RET    = 3'b100;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    top;
  logic [PW-1:0]    top_up;
  logic [WIDTH-1:0] pc_next;
  logic             do_push;
  logic             do_pop;
  logic             underflow;
  logic             overflow;

  assign pc_plus   = pc + WIDTH'(INC);
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == DEPTH_C);
  assign top_up    = top + PW'(1);

  always_comb begin
    pc_next   = pc_plus;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    underflow = 1'b0;
    case (mode)
      MODE_BRANCH: if (branch_taken) pc_next = pc + offset;
      MODE_JUMP:   pc_next = target;
      MODE_CALL: begin
        pc_next = target;
        do_push = 1'b1;
      end
      MODE_RET: begin
        if (ras_empty) begin
          underflow = 1'b1;
        end else begin
          pc_next = ras_mem[top];
          do_pop  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign overflow = do_push && ras_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= WIDTH'(RESET_PC);
      top       <= '0;
      ras_count <= '0;
      ras_err   <= 1'b0;
    end else if (pc_write) begin
      pc <= pc_next;
      if (do_push) begin
        // When full, the pointer advances onto the oldest slot, overwriting it.
        top <= top_up;
        if (!ras_full) ras_count <= ras_count + CW'(1);
      end else if (do_pop) begin
        top       <= top - PW'(1);
        ras_count <= ras_count - CW'(1);
      end
      if (overflow || underflow) ras_err <= 1'b1;
    end
  end

  // Stack storage carries no reset; stale entries are unreachable once count is zero.
  always_ff @(posedge clk) begin
    if (pc_write && do_push) ras_mem[top_up] <= pc_plus;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit (WIDTH=16, INC=2, RESET_PC=0, RAS_DEPTH=8).
// Vector tables and loops push expectations to a scoreboard queue, popped after each edge.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pc_write = 1'b0;
  logic [2:0]  mode = 3'b000;
  logic        branch_taken = 1'b0;
  logic [15:0] offset = '0;
  logic [15:0] target = '0;
  logic [15:0] pc;
  logic [15:0] pc_plus;
  logic        ras_empty;
  logic        ras_full;
  logic [3:0]  ras_count;
  logic        ras_err;

  pc_unit #(.WIDTH(16), .INC(2), .RESET_PC(0), .RAS_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .pc_write(pc_write), .mode(mode),
    .branch_taken(branch_taken), .offset(offset), .target(target),
    .pc(pc), .pc_plus(pc_plus), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_count(ras_count), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pw;
    logic [2:0]  md;
    logic        bt;
    logic [15:0] off;
    logic [15:0] tgt;
    logic [15:0] epc;
    int          ecnt;
    logic        eerr;
  } vec_t;

  typedef struct {
    logic [15:0] pc;
    int          cnt;
    logic        err;
  } exp_t;

  localparam logic [2:0] SEQ = 3'b000, BR = 3'b001, JMP = 3'b010, CALL = 3'b011, RET = 3'b100;

  int          total = 0;
  int          passed = 0;
  exp_t        sb[$];
  vec_t        vecs[$];
  logic [15:0] prev_pc = 16'h0000;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic pw, input logic [2:0] md, input logic bt,
                              input logic [15:0] off, input logic [15:0] tgt,
                              input logic [15:0] epc, input int ecnt, input logic eerr);
    vec_t v;
    v.pw = pw; v.md = md; v.bt = bt; v.off = off; v.tgt = tgt;
    v.epc = epc; v.ecnt = ecnt; v.eerr = eerr;
    return v;
  endfunction

  task automatic check_state(input string tag, input logic [15:0] epc, input int ecnt, input logic eerr);
    logic [15:0] epp;
    epp = epc + 16'd2;
    check({tag, ".pc"}, pc, epc);
    check({tag, ".pc_plus"}, pc_plus, epp);
    check({tag, ".ras_count"}, ras_count, ecnt);
    check({tag, ".ras_empty"}, ras_empty, (ecnt == 0) ? 1 : 0);
    check({tag, ".ras_full"}, ras_full, (ecnt == 8) ? 1 : 0);
    check({tag, ".ras_err"}, ras_err, eerr);
  endtask

  task automatic step(input string tag, input vec_t v);
    exp_t e;
    @(negedge clk);
    pc_write = v.pw; mode = v.md; branch_taken = v.bt; offset = v.off; target = v.tgt;
    sb.push_back('{v.epc, v.ecnt, v.eerr});
    #1 check({tag, ".no_comb_path"}, pc, prev_pc);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check_state(tag, e.pc, e.cnt, e.err);
      prev_pc = e.pc;
    end
  endtask

  // Asserts reset between edges and confirms it acts before the next rising edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    pc_write = 1'b1; mode = SEQ;
    #2 reset = 1'b0;
    #1 check_state(tag, 16'h0000, 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    pc_write = 1'b0;
    prev_pc = 16'h0000;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 check_state("reset", 16'h0000, 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    vecs.push_back(mk(1, SEQ,    0, 16'h0000, 16'h0000, 16'h0002, 0, 0));
    vecs.push_back(mk(1, SEQ,    0, 16'h0000, 16'h0000, 16'h0004, 0, 0));
    vecs.push_back(mk(1, SEQ,    0, 16'h0000, 16'h0000, 16'h0006, 0, 0));
    vecs.push_back(mk(1, SEQ,    0, 16'h0000, 16'h0000, 16'h0008, 0, 0));
    vecs.push_back(mk(1, BR,     1, 16'hFFFC, 16'h0000, 16'h0004, 0, 0));
    vecs.push_back(mk(1, SEQ,    0, 16'h0000, 16'h0000, 16'h0006, 0, 0));
    vecs.push_back(mk(1, SEQ,    0, 16'h0000, 16'h0000, 16'h0008, 0, 0));
    vecs.push_back(mk(1, BR,     0, 16'hFFFC, 16'h0000, 16'h000A, 0, 0));
    vecs.push_back(mk(1, JMP,    0, 16'h0000, 16'hFFFE, 16'hFFFE, 0, 0));
    vecs.push_back(mk(1, SEQ,    0, 16'h0000, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 3'b101, 1, 16'h0100, 16'h0500, 16'h0002, 0, 0));
    vecs.push_back(mk(1, 3'b111, 1, 16'h0100, 16'h0500, 16'h0004, 0, 0));
    vecs.push_back(mk(1, BR,     1, 16'h0010, 16'h0000, 16'h0014, 0, 0));
    vecs.push_back(mk(1, JMP,    1, 16'h0100, 16'h0020, 16'h0020, 0, 0));
    vecs.push_back(mk(1, CALL,   0, 16'h0000, 16'h0100, 16'h0100, 1, 0));
    vecs.push_back(mk(1, RET,    0, 16'h0000, 16'h0000, 16'h0022, 0, 0));
    vecs.push_back(mk(0, CALL,   0, 16'h0000, 16'h0300, 16'h0022, 0, 0));
    vecs.push_back(mk(0, CALL,   0, 16'h0000, 16'h0300, 16'h0022, 0, 0));
    vecs.push_back(mk(0, CALL,   0, 16'h0000, 16'h0300, 16'h0022, 0, 0));
    vecs.push_back(mk(1, CALL,   0, 16'h0000, 16'h0200, 16'h0200, 1, 0));
    vecs.push_back(mk(0, RET,    0, 16'h0000, 16'h0000, 16'h0200, 1, 0));
    vecs.push_back(mk(1, RET,    0, 16'h0000, 16'h0000, 16'h0024, 0, 0));
    vecs.push_back(mk(1, JMP,    0, 16'h0000, 16'h0040, 16'h0040, 0, 0));
    vecs.push_back(mk(1, RET,    0, 16'h0000, 16'h0000, 16'h0042, 0, 1));
    vecs.push_back(mk(1, SEQ,    0, 16'h0000, 16'h0000, 16'h0044, 0, 1));
    vecs.push_back(mk(0, CALL,   1, 16'h0000, 16'h0800, 16'h0044, 0, 1));
    vecs.push_back(mk(1, BR,     1, 16'h0000, 16'h0000, 16'h0044, 0, 1));

    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

    async_reset("midrun_reset");
    step("post_reset_seq", mk(1, SEQ, 0, 16'h0000, 16'h0000, 16'h0002, 0, 0));
    step("call_before_reset", mk(1, CALL, 0, 16'h0000, 16'h0300, 16'h0300, 1, 0));
    async_reset("reset_after_call");
    step("ret_after_reset", mk(1, RET, 0, 16'h0000, 16'h0000, 16'h0002, 0, 1));
    step("err_sticky", mk(1, SEQ, 0, 16'h0000, 16'h0000, 16'h0004, 0, 1));

    async_reset("reset_before_nest");
    for (int i = 0; i < 9; i++) begin
      logic [15:0] t;
      t = 16'h1000 + 16'(i * 16);
      step($sformatf("nest_call%0d", i),
           mk(1, CALL, 0, 16'h0000, t, t, (i + 1 > 8) ? 8 : i + 1, (i == 8) ? 1'b1 : 1'b0));
    end
    for (int j = 0; j < 8; j++) begin
      step($sformatf("nest_ret%0d", j),
           mk(1, RET, 0, 16'h0000, 16'h0000, 16'h1072 - 16'(j * 16), 7 - j, 1'b1));
    end
    step("ret_lost_entry", mk(1, RET, 0, 16'h0000, 16'h0000, 16'h1004, 0, 1));

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
